simmem_wdata_tracker: RTL and testbench

- Parametrised successor to the write-data counting wrapper in front of the delay calculator core.
- Pairs AXI write-data beats with write-address requests in AXI4 order.
- Forwards each address to the core with the count of beats received no later than that address (immediate count), and forwards later beats as single pulses.
- Keeps a bounded FIFO of accepted bursts, emits a per-burst "all data received" event carrying the burst's IID through a valid/ready handshake, applies bounded backpressure on write data, and flags WLAST protocol errors.

---
 rtl/simmem_pkg.sv | 32 +++
 rtl/simmem_wtrack_fifo.sv | 106 ++++++++++
 rtl/simmem_wdata_tracker.sv | 131 +++++++++++++
 tb/tb_simmem_wdata_tracker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simmem_pkg
// Description : Shared types and helpers for the simulated-memory write path.
//               Write IID type, AXI length width, the write-tracker FIFO
//               entry and the effective-burst-length helper.
// Revision    : 1.0 - write-data tracker entry type and length helper added
// ============================================================================
package simmem_pkg;

  localparam int unsigned WRspBankCapa   = 32;
  localparam int unsigned WriteIidWidth  = $clog2(WRspBankCapa);
  localparam int unsigned AxLenWidth     = 8;
  localparam int unsigned MaxBurstEffLen = 1 << AxLenWidth;

  typedef logic [WriteIidWidth-1:0] write_iid_t;

  // One extra bit so that the full effective length (len + 1) is representable.
  typedef logic [AxLenWidth:0] eff_len_t;

  // Tracker FIFO entry: burst IID and the number of beats still missing.
  typedef struct packed {
    write_iid_t iid;
    eff_len_t   remaining;
  } wtrack_entry_t;

  function automatic eff_len_t get_effective_burst_len(input logic [AxLenWidth-1:0] burst_len);
    return eff_len_t'(burst_len) + eff_len_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/simmem_wtrack_fifo.sv
`default_nettype none
// ============================================================================
// Module      : simmem_wtrack_fifo
// Description : Three-pointer burst FIFO. [rd, dat) holds complete bursts
//               waiting to be popped, [dat, wr) holds bursts still waiting
//               for beats. Each pointer has one wrap bit.
// Revision    : 1.0 - initial release
// Ports       : clk_i/rst_ni      clock, async active-low reset
//               push_i/push_entry_i  append entry at wr
//               beat_i            one beat for the entry at dat (caller only
//                                 asserts it when outstanding_cnt_o != 0)
//               pop_i             retire the entry at rd
//               full_o            Depth entries held
//               outstanding_cnt_o wr - dat
//               complete_cnt_o    dat - rd
//               dat_remaining_o   remaining beats of the entry at dat
//               rd_iid_o          IID of the entry at rd
// ============================================================================
module simmem_wtrack_fifo
  import simmem_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  wtrack_entry_t   push_entry_i,
  input  logic            beat_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic [PtrW-1:0] outstanding_cnt_o,
  output logic [PtrW-1:0] complete_cnt_o,
  output eff_len_t        dat_remaining_o,
  output write_iid_t      rd_iid_o
);

  localparam int unsigned IdxW = PtrW - 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] dat_ptr_q, dat_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  wtrack_entry_t   mem_q [Depth];
  wtrack_entry_t   mem_d [Depth];

  logic [IdxW-1:0] wr_idx, dat_idx, rd_idx;

  assign wr_idx  = wr_ptr_q[IdxW-1:0];
  assign dat_idx = dat_ptr_q[IdxW-1:0];
  assign rd_idx  = rd_ptr_q[IdxW-1:0];

  assign outstanding_cnt_o = wr_ptr_q - dat_ptr_q;
  assign complete_cnt_o    = dat_ptr_q - rd_ptr_q;
  assign full_o            = (wr_ptr_q - rd_ptr_q) == PtrW'(Depth);
  assign dat_remaining_o   = mem_q[dat_idx].remaining;
  assign rd_iid_o          = mem_q[rd_idx].iid;

  // A beat only touches the entry at dat while it is outstanding, so it never
  // aliases the push slot at wr; all three pointer updates are independent.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    dat_ptr_d = dat_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (beat_i) begin
      mem_d[dat_idx].remaining = mem_q[dat_idx].remaining - eff_len_t'(1);
      if (mem_q[dat_idx].remaining == eff_len_t'(1)) begin
        dat_ptr_d = dat_ptr_q + PtrW'(1);
      end
    end

    if (push_i) begin
      mem_d[wr_idx] = push_entry_i;
      wr_ptr_d      = wr_ptr_q + PtrW'(1);
      // A burst fully covered by early beats is complete on arrival; it can
      // only skip straight past dat when nothing older is still outstanding.
      if ((push_entry_i.remaining == '0) && (wr_ptr_q == dat_ptr_q)) begin
        dat_ptr_d = dat_ptr_q + PtrW'(1);
      end
    end

    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      dat_ptr_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      dat_ptr_q <= dat_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage is qualified entirely by the pointers and needs no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/simmem_wdata_tracker.sv
`default_nettype none
// ============================================================================
// Module      : simmem_wdata_tracker
// Description : Pairs AXI write-data beats with write addresses in order.
//               Forwards addresses with the count of beats already received,
//               forwards later beats as pulses, emits a per-burst done event
//               and flags WLAST mismatches.
// Revision    : 1.0 - parametrised successor of the write-data counter
// Ports       : clk_i/rst_ni                  clock, async active-low reset
//               waddr_*                       write address from requester
//               wdata_*                       write beats from requester
//               core_waddr_* / core_wdata_*   address and late beats to core
//               burst_done_*                  done event, valid/ready
//               wlast_err_o                   sticky WLAST mismatch
//               early_cnt_o                   beats held without an address
// ============================================================================
module simmem_wdata_tracker
  import simmem_pkg::*;
#(
  parameter int unsigned PendingDepth  = 8,
  parameter int unsigned MaxEarlyBeats = 64,
  parameter int unsigned IidWidth      = WriteIidWidth,
  parameter int unsigned LenWidth      = AxLenWidth,
  localparam int unsigned EarlyW       = $clog2(MaxEarlyBeats + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                waddr_valid_i,
  output logic                waddr_ready_o,
  input  logic [IidWidth-1:0] waddr_iid_i,
  input  logic [LenWidth-1:0] waddr_burst_len_i,
  input  logic                wdata_valid_i,
  output logic                wdata_ready_o,
  input  logic                wdata_last_i,
  output logic                core_waddr_valid_o,
  input  logic                core_waddr_ready_i,
  output logic [IidWidth-1:0] core_waddr_iid_o,
  output logic [LenWidth:0]   core_wdata_immediate_cnt_o,
  output logic                core_wdata_valid_o,
  output logic                burst_done_valid_o,
  input  logic                burst_done_ready_i,
  output logic [IidWidth-1:0] burst_done_iid_o,
  output logic                wlast_err_o,
  output logic [EarlyW-1:0]   early_cnt_o
);

  localparam int unsigned CntW = LenWidth + 1;
  localparam int unsigned CmpW = (EarlyW > CntW) ? EarlyW : CntW;
  localparam int unsigned PtrW = $clog2(PendingDepth) + 1;

  logic [EarlyW-1:0] early_cnt_q, early_cnt_d;
  logic              wlast_err_q, wlast_err_d;

  logic              fifo_full;
  logic [PtrW-1:0]   outstanding_cnt;
  logic [PtrW-1:0]   complete_cnt;
  eff_len_t          dat_remaining;
  write_iid_t        rd_iid;
  wtrack_entry_t     push_entry;

  logic              has_outstanding;
  logic              addr_hs, beat_hs, beat_to_burst, beat_early;
  logic [CmpW-1:0]   eff_len, early_plus, immediate;

  assign has_outstanding = (outstanding_cnt != '0);

  // Readies come from registered state only (plus the core's own ready).
  assign waddr_ready_o      = core_waddr_ready_i & ~fifo_full;
  assign wdata_ready_o      = has_outstanding | (early_cnt_q < EarlyW'(MaxEarlyBeats));
  assign core_waddr_valid_o = waddr_valid_i & ~fifo_full;
  assign core_waddr_iid_o   = waddr_iid_i;

  assign addr_hs       = waddr_valid_i & waddr_ready_o;
  assign beat_hs       = wdata_valid_i & wdata_ready_o;
  assign beat_to_burst = beat_hs & has_outstanding;
  assign beat_early    = beat_hs & ~has_outstanding;

  assign eff_len = CmpW'(get_effective_burst_len(AxLenWidth'(waddr_burst_len_i)));

  always_comb begin
    // The same-cycle beat is folded in first so it counts towards this address.
    early_plus = CmpW'(early_cnt_q) + CmpW'(beat_early);
    immediate  = '0;
    if (addr_hs) begin
      immediate = (early_plus < eff_len) ? early_plus : eff_len;
    end
    early_cnt_d = EarlyW'(early_plus - immediate);

    push_entry           = '0;
    push_entry.iid       = write_iid_t'(waddr_iid_i);
    push_entry.remaining = eff_len_t'(eff_len - immediate);

    wlast_err_d = wlast_err_q |
                  (beat_to_burst & (wdata_last_i != (dat_remaining == eff_len_t'(1))));
  end

  assign core_wdata_immediate_cnt_o = CntW'(immediate);
  assign core_wdata_valid_o         = beat_to_burst;
  assign burst_done_valid_o         = (complete_cnt != '0);
  assign burst_done_iid_o           = IidWidth'(rd_iid);
  assign wlast_err_o                = wlast_err_q;
  assign early_cnt_o                = early_cnt_q;

  simmem_wtrack_fifo #(
    .Depth (PendingDepth)
  ) u_fifo (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .push_i            (addr_hs),
    .push_entry_i      (push_entry),
    .beat_i            (beat_to_burst),
    .pop_i             (burst_done_valid_o & burst_done_ready_i),
    .full_o            (fifo_full),
    .outstanding_cnt_o (outstanding_cnt),
    .complete_cnt_o    (complete_cnt),
    .dat_remaining_o   (dat_remaining),
    .rd_iid_o          (rd_iid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      early_cnt_q <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      early_cnt_q <= early_cnt_d;
      wlast_err_q <= wlast_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simmem_wdata_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_simmem_wdata_tracker
// Description : Scoreboard bench for simmem_wdata_tracker. A queue-based
//               burst model predicts per-cycle status and handshake events;
//               a monitor compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simmem_wdata_tracker;
  import simmem_pkg::*;

  localparam int DEPTH = 8;
  localparam int MAXE  = 64;
  localparam int IIDW  = WriteIidWidth;
  localparam int LENW  = AxLenWidth;
  localparam int EW    = $clog2(MAXE + 1);

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            waddr_valid_i, waddr_ready_o;
  logic [IIDW-1:0] waddr_iid_i;
  logic [LENW-1:0] waddr_burst_len_i;
  logic            wdata_valid_i, wdata_ready_o, wdata_last_i;
  logic            core_waddr_valid_o, core_waddr_ready_i;
  logic [IIDW-1:0] core_waddr_iid_o;
  logic [LENW:0]   core_wdata_immediate_cnt_o;
  logic            core_wdata_valid_o;
  logic            burst_done_valid_o, burst_done_ready_i;
  logic [IIDW-1:0] burst_done_iid_o;
  logic            wlast_err_o;
  logic [EW-1:0]   early_cnt_o;

  always #5 clk = ~clk;

  simmem_wdata_tracker #(
    .PendingDepth (DEPTH),
    .MaxEarlyBeats(MAXE),
    .IidWidth     (IIDW),
    .LenWidth     (LENW)
  ) dut (
    .clk_i                      (clk),
    .rst_ni                     (rst_ni),
    .waddr_valid_i              (waddr_valid_i),
    .waddr_ready_o              (waddr_ready_o),
    .waddr_iid_i                (waddr_iid_i),
    .waddr_burst_len_i          (waddr_burst_len_i),
    .wdata_valid_i              (wdata_valid_i),
    .wdata_ready_o              (wdata_ready_o),
    .wdata_last_i               (wdata_last_i),
    .core_waddr_valid_o         (core_waddr_valid_o),
    .core_waddr_ready_i         (core_waddr_ready_i),
    .core_waddr_iid_o           (core_waddr_iid_o),
    .core_wdata_immediate_cnt_o (core_wdata_immediate_cnt_o),
    .core_wdata_valid_o         (core_wdata_valid_o),
    .burst_done_valid_o         (burst_done_valid_o),
    .burst_done_ready_i         (burst_done_ready_i),
    .burst_done_iid_o           (burst_done_iid_o),
    .wlast_err_o                (wlast_err_o),
    .early_cnt_o                (early_cnt_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic miss(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: DUT event with no expected entry (t=%0t)", nm, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int iid; int rem; } burst_t;
  typedef struct { bit ar; bit dr; bit cav; bit cwv; bit dv; int diid; bit er; int ec; int imm; } status_t;
  typedef struct { int iid; int imm; } addr_ev_t;

  burst_t   pend[$];     // bursts still waiting for beats, oldest first
  int       done_q[$];   // completed bursts not yet popped
  int       early = 0;
  bit       err   = 0;
  status_t  stat_q[$];
  addr_ev_t addr_q[$];
  int       pop_q[$];

  task automatic flush_model();
    pend.delete(); done_q.delete(); stat_q.delete(); addr_q.delete(); pop_q.delete();
    early = 0;
    err   = 0;
  endtask

  task automatic drive_cycle(input bit av, input int aiid, input int alen,
                             input bit dv, input bit dlast, input bit cr, input bit bdr);
    status_t s;
    bit ar, dr, ahs, bhs, room;
    int L, imm;
    room = (pend.size() + done_q.size()) < DEPTH;
    ar   = cr && room;
    dr   = (pend.size() > 0) || (early < MAXE);
    ahs  = av && ar;
    bhs  = dv && dr;
    s.ar = ar; s.dr = dr; s.cav = av && room;
    s.cwv = bhs && (pend.size() > 0);
    s.dv = done_q.size() > 0;
    s.diid = s.dv ? done_q[0] : 0;
    s.er = err; s.ec = early; s.imm = 0;
    if (s.dv && bdr) pop_q.push_back(done_q.pop_front());
    if (bhs) begin
      if (pend.size() > 0) begin
        if (dlast != (pend[0].rem == 1)) err = 1;
        pend[0].rem = pend[0].rem - 1;
        if (pend[0].rem == 0) begin
          done_q.push_back(pend[0].iid);
          void'(pend.pop_front());
        end
      end else begin
        early++;
      end
    end
    if (ahs) begin
      L   = alen + 1;
      imm = (early < L) ? early : L;
      early -= imm;
      s.imm = imm;
      addr_q.push_back('{aiid, imm});
      if ((L - imm == 0) && (pend.size() == 0)) done_q.push_back(aiid);
      else pend.push_back('{aiid, L - imm});
    end
    stat_q.push_back(s);
    waddr_valid_i      = av;
    waddr_iid_i        = IIDW'(aiid);
    waddr_burst_len_i  = LENW'(alen);
    wdata_valid_i      = dv;
    wdata_last_i       = dlast;
    core_waddr_ready_i = cr;
    burst_done_ready_i = bdr;
  endtask

  task automatic step(input bit av, input int aiid, input int alen,
                      input bit dv, input bit dlast, input bit cr, input bit bdr);
    @(posedge clk);
    #1;
    drive_cycle(av, aiid, alen, dv, dlast, cr, bdr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    status_t  s;
    addr_ev_t a;
    int       p;
    if (rst_ni === 1'b1) begin
      if (stat_q.size() == 0) miss("status");
      else begin
        s = stat_q.pop_front();
        chk("waddr_ready", waddr_ready_o, s.ar);
        chk("wdata_ready", wdata_ready_o, s.dr);
        chk("core_waddr_valid", core_waddr_valid_o, s.cav);
        chk("core_wdata_valid", core_wdata_valid_o, s.cwv);
        chk("done_valid", burst_done_valid_o, s.dv);
        if (s.dv) chk("done_iid_head", burst_done_iid_o, s.diid);
        chk("wlast_err", wlast_err_o, s.er);
        chk("early_cnt", early_cnt_o, s.ec);
        chk("immediate_cnt", core_wdata_immediate_cnt_o, s.imm);
      end
      if (core_waddr_valid_o && waddr_ready_o) begin
        if (addr_q.size() == 0) miss("addr_event");
        else begin
          a = addr_q.pop_front();
          chk("addr_iid", core_waddr_iid_o, a.iid);
          chk("addr_immediate", core_wdata_immediate_cnt_o, a.imm);
        end
      end
      if (burst_done_valid_o && burst_done_ready_i) begin
        if (pop_q.size() == 0) miss("done_event");
        else begin
          p = pop_q.pop_front();
          chk("done_pop_iid", burst_done_iid_o, p);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_ni = 1'b0;
    waddr_valid_i = 0; waddr_iid_i = '0; waddr_burst_len_i = '0;
    wdata_valid_i = 0; wdata_last_i = 0; core_waddr_ready_i = 1; burst_done_ready_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done_valid", burst_done_valid_o, 0);
    chk("rst_wdata_valid", core_wdata_valid_o, 0);
    chk("rst_err", wlast_err_o, 0);
    chk("rst_early", early_cnt_o, 0);
    rst_ni = 1'b1;
    drive_cycle(0, 0, 0, 0, 0, 1, 1);

    // Address first, then four beats with WLAST on the fourth.
    step(1, 3, 3, 0, 0, 1, 1);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, i == 4, 1, 1);
    idle(2);

    // Five early beats, then a 4-beat address.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 1, 1);
    step(1, 7, 3, 0, 0, 1, 1);
    idle(2);
    step(1, 8, 0, 0, 0, 1, 1);
    idle(2);

    // Early-beat ceiling.
    for (int i = 0; i < MAXE; i++) step(0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    step(1, 9, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    step(1, 10, 63, 0, 0, 1, 1);
    idle(2);

    // Fill the FIFO with beat+address same-cycle bursts while done is stalled.
    for (int k = 0; k < DEPTH; k++) step(1, 16 + k, 0, 1, 1, 1, 0);
    step(1, 30, 0, 0, 0, 1, 0);
    step(1, 30, 0, 0, 0, 1, 1);
    step(1, 30, 0, 1, 1, 1, 1);
    idle(10);

    // WLAST on the first beat of a two-beat burst.
    step(1, 5, 1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1, 1);
    idle(3);

    // Reset in the middle of a burst.
    step(1, 6, 3, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    waddr_valid_i = 0; wdata_valid_i = 0; wdata_last_i = 0; burst_done_ready_i = 0;
    core_waddr_ready_i = 1;
    #1;
    chk("mid_rst_err", wlast_err_o, 0);
    chk("mid_rst_done_valid", burst_done_valid_o, 0);
    chk("mid_rst_core_wvalid", core_wdata_valid_o, 0);
    chk("mid_rst_core_avalid", core_waddr_valid_o, 0);
    chk("mid_rst_early", early_cnt_o, 0);
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    drive_cycle(0, 0, 0, 0, 0, 1, 1);
    idle(2);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bit av, dv, dl, cr, bdr;
      int alen;
      av   = ($urandom_range(0, 99) < 35);
      dv   = ($urandom_range(0, 99) < 60);
      cr   = ($urandom_range(0, 99) < 85);
      bdr  = ($urandom_range(0, 99) < 60);
      alen = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 5);
      dl   = (pend.size() > 0) ? (pend[0].rem == 1) : 1'($urandom_range(0, 1));
      step(av, $urandom_range(0, (1 << IIDW) - 1), alen, dv, dl, cr, bdr);
    end
    idle(12);

    @(negedge clk);
    #1;
    chk("leftover_addr_events", addr_q.size(), 0);
    chk("leftover_done_events", pop_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
